mult_div_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, next to the ALU. It takes the two register-file read operands and produces the 64-bit HI/LO result pair for MULT/MULTU/DIV/DIVU. HI/LO are read back through MFHI/MFLO and written through MTHI/MTLO. While an operation runs, `busy` stalls the issuing pipeline.

---
 rtl/mult_div_unit_pkg.sv | 8 +
 rtl/mult_div_unit_md_step.sv | 19 +
 rtl/mult_div_unit.sv | 92 +++++++++
 tb/tb_mult_div_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op codes and FSM states shared by the multiply/divide unit.
package mult_div_unit_pkg;
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_t;
endpackage

// File: rtl/mult_div_unit_md_step.sv
// md_step: one radix-2 iteration, shift-add for multiply or trial-subtract-restore for divide.
module md_step #(
  parameter int N = 32
) (
  input  logic           div,
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   opnd,
  output logic [2*N-1:0] acc_next
);
  logic [N:0] sum;
  logic [N:0] trial;
  always_comb begin
    sum      = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? opnd : {N{1'b0}})};
    trial    = acc[2*N-1:N-1] - {1'b0, opnd};
    acc_next = !div     ? {sum, acc[N-1:1]} :
               trial[N] ? {acc[2*N-2:0], 1'b0} :
                          {trial[N-1:0], acc[N-2:0], 1'b1};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU producing HI/LO, with MTHI/MTLO writes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_wen,
  input  logic         lo_wen,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = $clog2(N);
  md_state_t      state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc, acc_nxt, prod;
  logic [N-1:0]   opnd, mag_a, mag_b, quo, rem;
  logic           is_div, neg_q, neg_r, dbz, sa, sb;
  md_step #(.N(N)) u_step (
    .div      (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_nxt)
  );
  // Signed ops run on magnitudes; signs are restored in FIX.
  always_comb begin
    sa    = !op[0] && inA[N-1];
    sb    = !op[0] && inB[N-1];
    mag_a = sa ? -inA : inA;
    mag_b = sb ? -inB : inB;
    prod  = neg_q ? -acc : acc;
    quo   = dbz ? {N{1'b1}} : neg_q ? -acc[N-1:0] : acc[N-1:0];
    rem   = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
  end
  always_comb begin
    busy      = state != MD_IDLE;
    state_nxt = state == MD_IDLE ? (start ? MD_RUN : MD_IDLE) :
                state == MD_RUN  ? (cnt == CW'(N-1) ? MD_FIX : MD_RUN) :
                                   MD_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= state == MD_FIX;
      if (state == MD_IDLE) begin
        if (hi_wen) hi <= wd;
        if (lo_wen) lo <= wd;
        if (start) begin
          cnt         <= '0;
          acc         <= {{N{1'b0}}, (op[1] ? mag_a : mag_b)};
          opnd        <= op[1] ? mag_b : mag_a;
          is_div      <= op[1];
          neg_q       <= sa ^ sb;
          neg_r       <= sa;
          dbz         <= op[1] && inB == '0;
          div_by_zero <= 1'b0;
        end
      end
      if (state == MD_RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
      if (state == MD_FIX) begin
        hi          <= is_div ? rem : prod[2*N-1:N];
        lo          <= is_div ? quo : prod[N-1:0];
        div_by_zero <= dbz;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for the iterative multiply/divide unit.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;
  logic        clock = 0, reset = 1, start = 0, hi_wen = 0, lo_wen = 0;
  logic [1:0]  op = 0;
  logic [31:0] inA = 0, inB = 0, wd = 0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  exp_t sb_q[$];

  mult_div_unit #(.N(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wd(wd), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sbv;
    logic [63:0] p;
    sa  = $signed(a);
    sbv = $signed(b);
    e   = '0;
    if (o == MD_MULT) begin
      p = sa * sbv;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == MD_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.lo = 32'hFFFFFFFF;
      e.hi = a;
      e.dbz = 1'b1;
    end else if (o == MD_DIV) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        e.lo = 32'h80000000;
        e.hi = 32'h0;
      end else begin
        e.lo = $signed(a) / $signed(b);
        e.hi = $signed(a) % $signed(b);
      end
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; inA = a; inB = b; start = 1;
    sb_q.push_back(model(o, a, b));
    @(posedge clock); #1;
    t0 = cyc; start = 0; inA = $urandom; inB = $urandom;
  endtask

  task automatic wait_done(output exp_t got, output exp_t e, output int lat);
    int n = 0;
    do begin @(negedge clock); n++; end while (done !== 1'b1 && n < 100);
    got = {hi, lo, div_by_zero};
    lat = (done === 1'b1) ? cyc - t0 + 1 : -1;
    e = sb_q.size() != 0 ? sb_q.pop_front() : '0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b dbz=%b hi=%h lo=%h want all zero", busy, done, div_by_zero, hi, lo);
    end
  endtask

  task automatic test_multu();
    exp_t got, e; int lat, bad = 0;
    launch(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    wait_done(got, e, lat);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_window bad_cycles=%0d want 0", bad); end
    checks++;
    if (lat != 34 || busy !== 1'b0) begin errors++; $display("FAIL multu_latency lat=%0d busy=%b want 34 0", lat, busy); end
    checks++;
    if (got !== e || got.hi !== 32'hFFFFFFFE || got.lo !== 32'h1) begin
      errors++;
      $display("FAIL multu_result hi=%h lo=%h want hi=fffffffe lo=00000001", got.hi, got.lo);
    end
  endtask

  task automatic test_mult();
    exp_t got, e; int lat;
    launch(MD_MULT, -32'sd3, 32'sd7);
    wait_done(got, e, lat);
    checks++;
    if (got !== e || got.lo !== 32'hFFFFFFEB || lat != 34) begin
      errors++;
      $display("FAIL mult_neg hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=34", got.hi, got.lo, lat, e.hi, e.lo);
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, e; int lat;
    launch(MD_DIV, -32'sd7, 32'sd2);
    wait_done(got, e, lat);
    checks++;
    if (got !== e || got.lo !== 32'hFFFFFFFD || got.hi !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_neg hi=%h lo=%h want hi=%h lo=%h", got.hi, got.lo, e.hi, e.lo);
    end
    launch(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(got, e, lat);
    checks++;
    if (got !== e || got.lo !== 32'h80000000 || got.hi !== 32'h0 || lat != 34) begin
      errors++;
      $display("FAIL div_overflow hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=34", got.hi, got.lo, lat, e.hi, e.lo);
    end
  endtask

  task automatic test_div_by_zero();
    exp_t got, e; int lat;
    launch(MD_DIVU, 32'd100, 32'd0);
    wait_done(got, e, lat);
    checks++;
    if (got !== e || got.lo !== 32'hFFFFFFFF || got.hi !== 32'd100 || got.dbz !== 1'b1 || lat != 34) begin
      errors++;
      $display("FAIL divu_zero hi=%h lo=%h dbz=%b lat=%0d want hi=00000064 lo=ffffffff dbz=1 lat=34", got.hi, got.lo, got.dbz, lat);
    end
    launch(MD_DIVU, 32'd100, 32'd7);
    @(negedge clock);
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear dbz=%b want 0", div_by_zero); end
    wait_done(got, e, lat);
    checks++;
    if (got !== e) begin errors++; $display("FAIL divu_after_zero hi=%h lo=%h want hi=%h lo=%h", got.hi, got.lo, e.hi, e.lo); end
    launch(MD_DIV, -32'sd5, 32'd0);
    wait_done(got, e, lat);
    checks++;
    if (got !== e || got.hi !== 32'hFFFFFFFB) begin
      errors++;
      $display("FAIL div_neg_zero hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b", got.hi, got.lo, got.dbz, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_mt();
    exp_t got, e; int lat;
    hi_wen = 1; wd = 32'hABC;
    launch(MD_MULTU, 32'd2, 32'd3);
    hi_wen = 0;
    @(negedge clock);
    checks++;
    if (hi !== 32'hABC) begin errors++; $display("FAIL mthi_with_start hi=%h want 00000abc", hi); end
    wait_done(got, e, lat);
    checks++;
    if (got !== e) begin errors++; $display("FAIL start_mt_overwrite hi=%h lo=%h want hi=%h lo=%h", got.hi, got.lo, e.hi, e.lo); end
    hi_wen = 1; wd = 32'h1234;
    @(posedge clock); #1 hi_wen = 0;
    @(negedge clock);
    checks++;
    if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_idle hi=%h want 00001234", hi); end
    lo_wen = 1; wd = 32'h5678;
    @(posedge clock); #1 lo_wen = 0;
    @(negedge clock);
    checks++;
    if (lo !== 32'h5678 || hi !== 32'h1234) begin errors++; $display("FAIL mtlo_idle lo=%h hi=%h want 00005678 00001234", lo, hi); end
  endtask

  task automatic test_mt_busy();
    exp_t got, e; int lat;
    launch(MD_MULTU, 32'd3, 32'd5);
    repeat (3) @(posedge clock);
    #1 lo_wen = 1; hi_wen = 1; wd = 32'hDEAD;
    @(posedge clock); #1 lo_wen = 0; hi_wen = 0;
    @(negedge clock);
    checks++;
    if (lo !== 32'h5678 || hi !== 32'h1234) begin errors++; $display("FAIL mt_busy lo=%h hi=%h want 00005678 00001234", lo, hi); end
    wait_done(got, e, lat);
    checks++;
    if (got !== e || lat != 34) begin errors++; $display("FAIL mt_busy_result hi=%h lo=%h lat=%0d want hi=%h lo=%h", got.hi, got.lo, lat, e.hi, e.lo); end
  endtask

  task automatic test_start_busy();
    exp_t got, e; int lat;
    launch(MD_MULT, 32'd12345, -32'sd99);
    repeat (4) @(posedge clock);
    #1 start = 1; op = MD_DIVU; inA = 32'd1; inB = 32'd0;
    @(posedge clock); #1 start = 0;
    wait_done(got, e, lat);
    checks++;
    if (got !== e || lat != 34) begin
      errors++;
      $display("FAIL start_while_busy hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=34", got.hi, got.lo, got.dbz, lat, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_reset_midrun();
    exp_t got, e, dropped; int lat;
    launch(MD_DIVU, 32'd1000, 32'd3);
    dropped = sb_q.pop_back();
    repeat (9) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    checks++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      errors++;
      $display("FAIL reset_midrun busy=%b done=%b hi=%h lo=%h want all zero (dropped lo=%h)", busy, done, hi, lo, dropped.lo);
    end
    launch(MD_MULTU, 32'd6, 32'd7);
    wait_done(got, e, lat);
    checks++;
    if (got !== e || got.lo !== 32'd42 || got.hi !== 32'd0 || lat != 34) begin
      errors++;
      $display("FAIL post_reset_mult hi=%h lo=%h lat=%0d want hi=0 lo=2a lat=34", got.hi, got.lo, lat);
    end
  endtask

  task automatic test_random();
    exp_t got, e; int lat;
    logic [1:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom_range(0, 4) == 0 ? 32'd0 : ($urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(1, 300)));
      launch(o, a, b);
      wait_done(got, e, lat);
      checks++;
      if (got !== e || lat != 34) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b", i, o, a, b, got.hi, got.lo, got.dbz, lat, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_back_to_back();
    test_div_by_zero();
    test_mt();
    test_mt_busy();
    test_start_busy();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
